// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the UART transmit path: sequencer state encodings
// and the default character width.
package uart_tx_buffer_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_SEND = 2'b10,
        ST_WAIT = 2'b11
    } seq_state_e;

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Circular byte buffer with occupancy count; writes while full and reads
// while empty are ignored.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_W:0]       count_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic                  do_push, do_pop;

    assign full_o    = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A push is refused while full even if a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus send sequencer feeding the UART transmitter: one tx_send
// per queued byte, tx_data held stable until the transmitter reports done.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  ovf_clr,
    input  logic                  tx_done,
    output logic                  tx_send,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_busy,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_W:0]       count,
    output logic                  overflow
);

    seq_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  overflow_q, overflow_d;
    logic                  pop;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_full, fifo_empty;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (wr_en),
        .pop_i     (pop),
        .wr_data_i (wr_data),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (count)
    );

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD: begin
                tx_data_d = fifo_rd_data;
                pop       = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: if (tx_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear wins over a same-cycle dropped write.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_en && fifo_full) overflow_d = 1'b1;
        if (ovf_clr)            overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_send  = (state_q == ST_SEND);
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_data  = tx_data_q;
    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed self-checking bench for uart_tx_buffer.
module tb_uart_tx_buffer;

    logic       clk = 1'b0;
    logic       rst, wr_en, ovf_clr, tx_done;
    logic [7:0] wr_data;
    logic       tx_send, tx_busy, full, empty, overflow;
    logic [7:0] tx_data;
    logic [3:0] count;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         sends    = 0;
    bit         outstanding = 1'b0;
    logic [7:0] got[$];

    uart_tx_buffer #(
        .DATA_WIDTH (8),
        .DEPTH      (8),
        .ADDR_W     (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .tx_done  (tx_done),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (tx_send === 1'b1) begin
            got.push_back(tx_data);
            sends++;
            outstanding = 1'b1;
        end
    endtask

    task automatic write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    // Transmitter model: answers each tx_send with tx_done after dly cycles.
    task automatic drain(input int n, input int dly);
        for (int it = 0; it < 2000; it++) begin
            if (outstanding) begin
                repeat (dly) step();
                pulse_done();
                outstanding = 1'b0;
            end else if (got.size() >= n) begin
                break;
            end else begin
                step();
            end
        end
        check("drain_count", got.size(), n);
    endtask

    initial begin
        int         peak;
        int         snap;
        bit         held;
        logic [7:0] b;

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0; tx_done = 1'b0;
        step(); step();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_send", tx_send, 0);
        check("rst_data", tx_data, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        step();

        // Single byte, done returned 20 cycles after tx_send.
        got.delete(); sends = 0;
        write(8'h41);
        check("t1_empty_after_write", empty, 0);
        check("t1_busy_n", tx_busy, 0);
        step();
        check("t1_load_busy", tx_busy, 1);
        check("t1_load_nosend", tx_send, 0);
        step();
        check("t1_send", tx_send, 1);
        check("t1_data", tx_data, 8'h41);
        held = 1'b1;
        repeat (19) begin
            step();
            if (tx_data !== 8'h41 || tx_send !== 1'b0) held = 1'b0;
        end
        check("t1_held", held, 1);
        pulse_done(); outstanding = 1'b0;
        check("t1_idle", tx_busy, 0);
        check("t1_empty_end", empty, 1);
        repeat (3) step();
        check("t1_sends", sends, 1);

        // Burst of 8 with early pop; count peaks at 7.
        got.delete(); sends = 0; peak = 0;
        for (int i = 0; i < 8; i++) begin
            write(8'h10 + 8'(i));
            if (int'(count) > peak) peak = int'(count);
        end
        check("t2_peak", peak, 7);
        drain(8, 3);
        for (int i = 0; i < 8; i++) check("t2_order", got[i], 8'h10 + 8'(i));
        repeat (5) step();
        check("t2_sends", sends, 8);
        check("t2_empty", empty, 1);

        // Fill with a stalled transmitter: 8 queued + 1 in flight, 10th dropped.
        got.delete(); sends = 0;
        for (int i = 0; i < 9; i++) begin
            write(8'h20 + 8'(i));
            check("t3_no_ovf", overflow, 0);
        end
        check("t3_full", full, 1);
        check("t3_count", count, 8);
        write(8'h29);
        check("t3_ovf_set", overflow, 1);
        check("t3_count_drop", count, 8);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("t3_ovf_clr", overflow, 0);
        ovf_clr = 1'b1; write(8'h2A); ovf_clr = 1'b0;
        check("t3_clr_priority", overflow, 0);
        check("t3_count_still", count, 8);
        drain(9, 1);
        for (int i = 0; i < 9; i++) check("t3_order", got[i], 8'h20 + 8'(i));

        // Push coinciding with pop in LOAD at count=3.
        got.delete(); sends = 0;
        write(8'hA0);
        repeat (3) step();
        check("t4_a0_sent", outstanding, 1);
        write(8'hB1); write(8'hB2); write(8'hB3);
        check("t4_count3", count, 3);
        pulse_done(); outstanding = 1'b0;
        step();
        check("t4_load", tx_busy, 1);
        check("t4_load_nosend", tx_send, 0);
        write(8'hB4);
        check("t4_count_same", count, 3);
        drain(5, 2);
        check("t4_b0", got[0], 8'hA0);
        check("t4_b1", got[1], 8'hB1);
        check("t4_b2", got[2], 8'hB2);
        check("t4_b3", got[3], 8'hB3);
        check("t4_b4_last", got[4], 8'hB4);

        // Three pointer wrap-arounds, two bytes queued per round.
        got.delete(); sends = 0;
        for (int i = 0; i < 24; i += 2) begin
            write(8'(i * 7 + 3));
            write(8'((i + 1) * 7 + 3));
            drain(i + 2, 1);
        end
        for (int i = 0; i < 24; i++) begin
            b = 8'(i * 7 + 3);
            check("t5_wrap", got[i], b);
        end

        // Reset during WAIT with four bytes queued.
        got.delete(); sends = 0;
        for (int i = 0; i < 5; i++) write(8'hC0 + 8'(i));
        check("t6_count4", count, 4);
        check("t6_wait_busy", tx_busy, 1);
        check("t6_wait_nosend", tx_send, 0);
        rst = 1'b1; step(); rst = 1'b0; outstanding = 1'b0;
        check("t6_busy", tx_busy, 0);
        check("t6_count", count, 0);
        check("t6_empty", empty, 1);
        check("t6_send", tx_send, 0);
        check("t6_data", tx_data, 0);
        snap = sends;
        pulse_done();
        repeat (4) step();
        check("t6_late_done_busy", tx_busy, 0);
        check("t6_late_done_sends", sends, snap);

        // tx_done while idle and empty.
        snap = sends;
        pulse_done();
        check("t7_busy", tx_busy, 0);
        repeat (3) step();
        check("t7_busy_later", tx_busy, 0);
        check("t7_sends", sends, snap);
        check("t7_empty", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
